// File: rtl/trace_line_emitter.sv
// rtl/trace_line_emitter.sv - serialises one register/memory write event into an ASCII trace line
// Optional `TRACE_NEWLINE_EN appends 8'h0A after '#'; HEX_UPPER selects hex letter case.
module trace_line_emitter #(
  parameter int HEX_UPPER = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_type,
  input  logic [13:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_reg,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char,
  output logic        char_valid,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SIGIL,
    S_DEST, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH
`ifdef TRACE_NEWLINE_EN
    , S_NL
`endif
  } state_t;

`ifdef TRACE_NEWLINE_EN
  localparam state_t S_LAST = S_NL;
`else
  localparam state_t S_LAST = S_HASH;
`endif

  state_t      r_state;
  logic [2:0]  r_idx;
  logic        r_type;
  logic [15:0] r_bcd;
  logic [1:0]  r_tdig_m1;
  logic        r_rdig_m1;
  logic [31:0] r_pc;
  logic [31:0] r_dest;
  logic [31:0] r_data;
  logic [7:0]  r_char;
  logic        r_char_valid;
  logic        r_done;

  state_t      w_state_nxt;
  logic [2:0]  w_idx_nxt;
  logic        w_accept;
  logic [13:0] w_time_sat;
  logic [29:0] w_dd;
  logic [15:0] w_bcd;
  logic [1:0]  w_tdig_m1;
  logic [1:0]  w_reg_tens;
  logic [4:0]  w_reg_units;
  logic [31:0] w_field;
  logic [31:0] w_field_sh;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;
  logic [7:0]  w_char_nxt;

  assign in_ready   = (r_state == S_IDLE) || (r_state == S_LAST);
  assign w_accept   = in_valid && in_ready;
  assign char       = r_char;
  assign char_valid = r_char_valid;
  assign done       = r_done;

  // Double-dabble on the saturated time, done combinationally so the line gains no cycles.
  always_comb begin
    w_time_sat = (in_time > 14'd9999) ? 14'd9999 : in_time;
    w_dd = {16'd0, w_time_sat};
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (w_dd[14+4*k +: 4] >= 4'd5) begin
          w_dd[14+4*k +: 4] = w_dd[14+4*k +: 4] + 4'd3;
        end
      end
      w_dd = w_dd << 1;
    end
    w_bcd = w_dd[29:14];
    if (w_bcd[15:12] != 4'd0)     w_tdig_m1 = 2'd3;
    else if (w_bcd[11:8] != 4'd0) w_tdig_m1 = 2'd2;
    else if (w_bcd[7:4] != 4'd0)  w_tdig_m1 = 2'd1;
    else                          w_tdig_m1 = 2'd0;
  end

  always_comb begin
    if (in_reg >= 5'd30)      begin w_reg_tens = 2'd3; w_reg_units = in_reg - 5'd30; end
    else if (in_reg >= 5'd20) begin w_reg_tens = 2'd2; w_reg_units = in_reg - 5'd20; end
    else if (in_reg >= 5'd10) begin w_reg_tens = 2'd1; w_reg_units = in_reg - 5'd10; end
    else                      begin w_reg_tens = 2'd0; w_reg_units = in_reg;         end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CARET;
      S_CARET: begin w_state_nxt = S_TIME; w_idx_nxt = {1'b0, r_tdig_m1}; end
      S_TIME:  if (r_idx == 3'd0) w_state_nxt = S_AT; else w_idx_nxt = r_idx - 3'd1;
      S_AT:    begin w_state_nxt = S_PC; w_idx_nxt = 3'd7; end
      S_PC:    if (r_idx == 3'd0) w_state_nxt = S_COLON; else w_idx_nxt = r_idx - 3'd1;
      S_COLON: w_state_nxt = S_SP1;
      S_SP1:   w_state_nxt = S_SIGIL;
      S_SIGIL: begin
        w_state_nxt = S_DEST;
        w_idx_nxt   = r_type ? 3'd7 : {2'b00, r_rdig_m1};
      end
      S_DEST:  if (r_idx == 3'd0) w_state_nxt = S_SP2; else w_idx_nxt = r_idx - 3'd1;
      S_SP2:   w_state_nxt = S_LT;
      S_LT:    w_state_nxt = S_EQ;
      S_EQ:    w_state_nxt = S_SP3;
      S_SP3:   begin w_state_nxt = S_DATA; w_idx_nxt = 3'd7; end
      S_DATA:  if (r_idx == 3'd0) w_state_nxt = S_HASH; else w_idx_nxt = r_idx - 3'd1;
`ifdef TRACE_NEWLINE_EN
      S_HASH:  w_state_nxt = S_NL;
      S_NL:    w_state_nxt = w_accept ? S_CARET : S_IDLE;
`else
      S_HASH:  w_state_nxt = w_accept ? S_CARET : S_IDLE;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // The output character is looked up for the state being entered, so char stays registered.
  always_comb begin
    case (w_state_nxt)
      S_TIME:  w_field = {16'd0, r_bcd};
      S_PC:    w_field = r_pc;
      S_DEST:  w_field = r_dest;
      default: w_field = r_data;
    endcase
    w_field_sh = w_field >> {w_idx_nxt, 2'b00};
    w_nib = w_field_sh[3:0];
    if (w_nib < 4'd10)       w_hex = 8'h30 + {4'h0, w_nib};
    else if (HEX_UPPER != 0) w_hex = 8'h37 + {4'h0, w_nib};
    else                     w_hex = 8'h57 + {4'h0, w_nib};
    case (w_state_nxt)
      S_CARET: w_char_nxt = 8'h5E;
      S_AT:    w_char_nxt = 8'h40;
      S_COLON: w_char_nxt = 8'h3A;
      S_SP1, S_SP2, S_SP3: w_char_nxt = 8'h20;
      S_SIGIL: w_char_nxt = r_type ? 8'h2A : 8'h24;
      S_LT:    w_char_nxt = 8'h3C;
      S_EQ:    w_char_nxt = 8'h3D;
      S_HASH:  w_char_nxt = 8'h23;
`ifdef TRACE_NEWLINE_EN
      S_NL:    w_char_nxt = 8'h0A;
`endif
      S_TIME, S_PC, S_DEST, S_DATA: w_char_nxt = w_hex;
      default: w_char_nxt = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= 3'd0;
      r_char       <= 8'h00;
      r_char_valid <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_char       <= w_char_nxt;
      r_char_valid <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_LAST);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_type    <= 1'b0;
      r_bcd     <= 16'd0;
      r_tdig_m1 <= 2'd0;
      r_rdig_m1 <= 1'b0;
      r_pc      <= 32'd0;
      r_dest    <= 32'd0;
      r_data    <= 32'd0;
    end else if (w_accept) begin
      r_type    <= in_type;
      r_bcd     <= w_bcd;
      r_tdig_m1 <= w_tdig_m1;
      r_rdig_m1 <= (w_reg_tens != 2'd0);
      r_pc      <= in_pc;
      r_dest    <= in_type ? in_addr : {24'd0, 2'b00, w_reg_tens, w_reg_units[3:0]};
      r_data    <= in_data;
    end
  end

endmodule

// File: tb/tb_trace_line_emitter.sv
// tb/tb_trace_line_emitter.sv - directed bench for trace_line_emitter
// Expected lines are hand-written; `TRACE_NEWLINE_EN adds the trailing newline to each.
`timescale 1ns/1ps
module tb_trace_line_emitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_type;
  logic [13:0] in_time;
  logic [31:0] in_pc;
  logic [4:0]  in_reg;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic        in_ready, char_valid, done;
  logic [7:0]  char;
  logic        u_in_ready, u_char_valid, u_done;
  logic [7:0]  u_char;

  int tests = 0;
  int fails = 0;

`ifdef TRACE_NEWLINE_EN
  string      nl = "\n";
  logic [7:0] lastch = 8'h0A;
`else
  string      nl = "";
  logic [7:0] lastch = 8'h23;
`endif

  always #5 clk = ~clk;

  trace_line_emitter #(.HEX_UPPER(0)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
    .in_addr(in_addr), .in_data(in_data), .char(char), .char_valid(char_valid), .done(done)
  );

  trace_line_emitter #(.HEX_UPPER(1)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(u_in_ready),
    .in_type(in_type), .in_time(in_time), .in_pc(in_pc), .in_reg(in_reg),
    .in_addr(in_addr), .in_data(in_data), .char(u_char), .char_valid(u_char_valid), .done(u_done)
  );

`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s observed=%0h expected=%0h", tag, (obs), (exp)); end end
`define CHKS(tag, obs, exp) begin tests++; assert ((obs) == (exp)) else begin fails++; $error("FAIL %s observed=\"%s\" expected=\"%s\"", tag, (obs), (exp)); end end

  task automatic send(input logic t, input logic [13:0] tm, input logic [31:0] pc,
                      input logic [4:0] rg, input logic [31:0] ad, input logic [31:0] dt);
    @(negedge clk);
    in_type = t; in_time = tm; in_pc = pc; in_reg = rg; in_addr = ad; in_data = dt;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_type = ~t; in_time = ~tm; in_pc = ~pc; in_reg = ~rg; in_addr = ~ad; in_data = ~dt;
  endtask

  task automatic collect(output string s, output string su, output int n_done,
                         output logic last_ok, output int rdy_bad, output logic first_ok);
    s = ""; su = ""; n_done = 0; last_ok = 1'b0; rdy_bad = 0; first_ok = 1'b0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == 0) first_ok = char_valid && (char == 8'h5E);
      if (char_valid) begin
        s  = {s, $sformatf("%c", char)};
        su = {su, $sformatf("%c", u_char)};
      end
      if (char_valid && !done && in_ready) rdy_bad++;
      if (done) begin
        n_done++;
        last_ok = (char == lastch);
        break;
      end
    end
  endtask

  string s, su, exp1, exp2, bb;
  int    n_done, rdy_bad, gaps, nd;
  logic  last_ok, first_ok, pend;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_type = 1'b0; in_time = '0;
    in_pc = '0; in_reg = '0; in_addr = '0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    `CHK("reset_char", char, 8'h00)
    `CHK("reset_char_valid", char_valid, 1'b0)
    `CHK("reset_done", done, 1'b0)
    `CHK("reset_in_ready", in_ready, 1'b1)

    send(1'b0, 14'd10, 32'h0000_3000, 5'd1, 32'h0, 32'h0000_001f);
    collect(s, su, n_done, last_ok, rdy_bad, first_ok);
    exp1 = {"^10@00003000: $1 <= 0000001f#", nl};
    `CHKS("reg_line", s, exp1)
    `CHK("reg_len", s.len(), 29 + nl.len())
    `CHK("reg_first_caret", first_ok, 1'b1)
    `CHK("reg_done_count", n_done, 1)
    `CHK("reg_done_on_last", last_ok, 1'b1)
    `CHK("reg_ready_busy", rdy_bad, 0)
    @(negedge clk);
    `CHK("idle_char", char, 8'h00)
    `CHK("idle_char_valid", char_valid, 1'b0)

    send(1'b1, 14'd0, 32'h0000_3004, 5'd0, 32'h0, 32'hffff_ffff);
    collect(s, su, n_done, last_ok, rdy_bad, first_ok);
    `CHKS("mem_line_lower", s, {"^0@00003004: *00000000 <= ffffffff#", nl})
    `CHKS("mem_line_upper", su, {"^0@00003004: *00000000 <= FFFFFFFF#", nl})
    `CHK("mem_len", s.len(), 35 + nl.len())

    send(1'b0, 14'd12000, 32'h0000_abcd, 5'd31, 32'h0, 32'h1234_5678);
    collect(s, su, n_done, last_ok, rdy_bad, first_ok);
    `CHKS("sat_line", s, {"^9999@0000abcd: $31 <= 12345678#", nl})
    `CHK("sat_len", s.len(), 32 + nl.len())
    `CHK("sat_done_on_last", last_ok, 1'b1)

    exp1 = {"^5@00000010: $0 <= deadbeef#", nl};
    exp2 = {"^123@00003008: *10010000 <= 00000001#", nl};
    @(negedge clk);
    in_type = 1'b0; in_time = 14'd5; in_pc = 32'h0000_0010; in_reg = 5'd0;
    in_addr = 32'h0; in_data = 32'hdead_beef; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_type = 1'b1; in_time = 14'd123; in_pc = 32'h0000_3008; in_reg = 5'd9;
    in_addr = 32'h1001_0000; in_data = 32'h0000_0001;
    bb = ""; gaps = 0; nd = 0; pend = 1'b0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (pend) begin in_valid = 1'b0; pend = 1'b0; end
      if (char_valid) bb = {bb, $sformatf("%c", char)};
      else gaps++;
      if (done) begin
        nd++;
        if (nd == 1) pend = 1'b1;
        if (nd == 2) break;
      end
    end
    in_valid = 1'b0;
    `CHKS("b2b_lines", bb, {exp1, exp2})
    `CHK("b2b_gaps", gaps, 0)
    `CHK("b2b_done_count", nd, 2)

    send(1'b0, 14'd10, 32'h0000_3000, 5'd1, 32'h0, 32'h0000_001f);
    repeat (5) @(negedge clk);
    `CHK("mid_pc_char", char, 8'h30)
    #2;
    reset = 1'b1;
    #1;
    `CHK("async_rst_char", char, 8'h00)
    `CHK("async_rst_char_valid", char_valid, 1'b0)
    `CHK("async_rst_done", done, 1'b0)
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    `CHK("post_rst_ready", in_ready, 1'b1)
    `CHK("post_rst_char_valid", char_valid, 1'b0)
    send(1'b0, 14'd7, 32'h0000_3010, 5'd7, 32'h0, 32'h0bad_f00d);
    collect(s, su, n_done, last_ok, rdy_bad, first_ok);
    `CHKS("post_rst_line", s, {"^7@00003010: $7 <= 0badf00d#", nl})
    `CHK("post_rst_first_caret", first_ok, 1'b1)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/trace_line_emitter.md
Name: trace_line_emitter

Overview:
- Serializer directly upstream of the CPU trace checker.
- Accepts one write-back/store event per handshake and emits its canonical ASCII trace line, one character per clock, on the `char` bus the checker samples every cycle.
- The checker expects register lines `^<time>@<pc>: $<grf> <= <data>#` and memory lines `^<time>@<pc>: *<addr> <= <data>#`. This block generates exactly those for bench stimulus and on-board self-test.

Parameters:
- HEX_UPPER, 0, 1 = hex digits a-f emitted as 'A'-'F'; 0 = 'a'-'f'.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  event present
- in_ready  output  1  block can accept an event this cycle
- in_type  input  1  0 = register line ('$'), 1 = memory line ('*')
- in_time  input  14  simulation time, binary
- in_pc  input  32  PC value
- in_reg  input  5  GRF index (used when in_type=0)
- in_addr  input  32  memory address (used when in_type=1)
- in_data  input  32  written data
- char  output  8  ASCII character, registered
- char_valid  output  1  char holds a line character this cycle
- done  output  1  one-cycle pulse coincident with the final character of a line

Behaviour:
- Reset (async): char=8'h00, char_valid=0, done=0, FSM=IDLE, all captured fields cleared. in_ready=1 after reset.
- Accept: when in_valid && in_ready at a rising edge. All inputs are captured in that edge; later input changes have no effect on the line.
- in_ready is 1 in IDLE, and also in the cycle the final character is driven.
- Latency: '^' is on char the cycle after accept. Back-to-back accepts produce contiguous lines with no gap.
- FSM sequence: IDLE -> CARET('^') -> TIME -> AT('@') -> PC -> COLON(':') -> SP1(' ') -> SIGIL('$' or '*') -> DEST -> SP2(' ') -> LT('<') -> EQ('=') -> SP3(' ') -> DATA -> HASH('#') -> IDLE, or straight to CARET on a new accept.
- TIME field:
  - Decimal, leading zeros suppressed, at least one digit, 1..4 digits.
  - in_time > 9999 saturates to 9999.
  - Binary-to-BCD conversion completes at capture or inside CARET; it must not add cycles.
- PC field: exactly 8 hex digits, MSB nibble first, leading zeros kept.
- DEST field:
  - Register line: decimal GRF index 0..31, no leading zeros ("0", "7", "31").
  - Memory line: in_addr as 8 hex digits.
- DATA field: 8 hex digits.
- Digit counters: a 3-bit nibble index walks 7 down to 0 for hex fields; a digit count plus index drives the decimal fields.
- Line length:
  - Register line: 26 + T + R chars (T = time digits, R = reg digits).
  - Memory line: 34 + T chars.
- char_valid is 1 for every emitted character and 0 in IDLE. In IDLE, char=8'h00.
- done=1 only alongside '#' (or '\n' when the newline option is enabled).
- Reset mid-line: output returns to 8'h00 / char_valid=0 immediately (async) and the partial line is abandoned. No resumption after reset release.
- in_valid while busy (not the final-char cycle): ignored and not queued; the upstream source must hold it.

Optional Feature:
- TRACE_NEWLINE_EN defined:
  - NL state after HASH emits 8'h0A.
  - done moves to the NL cycle and in_ready asserts in the NL cycle.
  - Line length +1.
- Not defined: line ends at '#'; no NL state exists.

Test Plan:
- Register line: type=0, time=10, pc=0x00003000, reg=1, data=0x0000001f -> "^10@00003000: $1 <= 0000001f#" over 29 consecutive cycles starting 1 cycle after accept; done with '#'.
- Memory line: type=1, time=0, pc=0x00003004, addr=0, data=0xffffffff -> "^0@00003004: *00000000 <= ffffffff#" (35 chars). With HEX_UPPER=1 the data field is "FFFFFFFF".
- Saturation/width: time=12000, reg=31 -> time field "9999", dest "31", 32 chars total.
- Back-to-back: second event held valid during the first line -> accepted on the '#' cycle; its '^' appears the next cycle with no gap; char_valid never drops.
- Reset mid-line: assert reset during the PC field -> char=0x00 and char_valid=0 with no clock edge; after release in_ready=1 and a new event emits a complete fresh line.
- TRACE_NEWLINE_EN build: register line above -> 30 chars ending "#\n"; done on the 0x0A cycle.
